control_turnos: RTL and testbench
=================================

# control_turnos

Turn sequencer and shot arbiter for the two 5x5 battleship boards (player and PC, 2-bit cells: 00 water, 01 ship, 10 missed shot, 11 hit shot). It alternates turns between the player input path and the PC shot generator. Each accepted shot is a read-modify-write on the opposing board's cell. The block keeps per-side hit counts, clears the boards at game start, and declares the winner. It sits between the input/PC-logic blocks and the board storage; the VGA path reads the boards.

## Interface
- N, 5, board dimension (rows = cols)
- SHIP_CELLS, 3, hits needed to win
- TIMEOUT_CYCLES, 15, player-turn timeout (only with TURN_TIMEOUT_EN)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: new game
- jug_valid / jug_ready  in/out  1  player shot handshake
- jug_row, jug_col  in  3  player target
- pc_valid / pc_ready  in/out  1  PC shot handshake
- pc_row, pc_col  in  3  PC target
- rd_board  out  1  0 = player board, 1 = PC board
- rd_row, rd_col  out  3  read address
- cell_rd  in  2  combinational cell content at rd_* address
- wr_en  out  1  one-cycle write strobe
- wr_board, wr_row, wr_col, wr_data  out  1/3/3/2  write command
- clear_boards  out  1  one-cycle pulse; drives the boards' decision_State
- turno  out  1  0 = player, 1 = PC
- hits_jug, hits_pc  out  $clog2(SHIP_CELLS+1)  hit counters
- shot_err  out  1  one-cycle pulse: rejected shot
- timeout  out  1  one-cycle pulse: player turn expired
- game_over, ganador  out  1  end flag; winner (0 player, 1 PC)

## Operation
- States: IDLE, T_JUG, CHK_JUG, T_PC, CHK_PC, FIN.
- Reset: state IDLE. All outputs 0: rd_*, wr_*, counters, pulses, turno, game_over, ganador. A pending write is dropped.
- IDLE or FIN + start:
  - clear_boards pulses for 1 cycle.
  - Hit counters clear; game_over, ganador clear.
  - Next state T_JUG.
  - start in any other state is ignored.
- T_JUG:
  - jug_ready = 1, combinational from state.
  - jug_valid & jug_ready accepts; coordinates latch into rd_row/rd_col with rd_board = 1.
  - Next state CHK_JUG.
- T_PC: same, using pc_* and rd_board = 0. pc_ready = 1 only in T_PC.
- CHK_*: evaluate the target.
  - Out of range (row or col ≥ N) or cell_rd[1] = 1 (already shot): shot_err pulses, no write, return to the same T_ state.
  - cell_rd = 00: write 10, turn passes to the opponent.
  - cell_rd = 01: write 11, shooter's hit counter +1, turn passes to the opponent.
  - If the incremented counter equals SHIP_CELLS: go to FIN, game_over = 1, ganador = shooter.
- Write target: wr_board = rd_board, wr_row = rd_row, wr_col = rd_col.
- turno = 1 in T_PC/CHK_PC, otherwise 0.
- FIN: game_over holds. Both ready outputs are 0. Boards are not touched until start.
- Counters saturate at SHIP_CELLS and never wrap.

## Timing
- Shot accepted at edge T: rd_* valid from T+1 (state CHK).
- Cell evaluated in cycle T+1. wr_en, counter update, shot_err, game_over and the new turno are all registered and visible at T+2.
- wr_en is high for exactly one cycle per valid shot.
- Minimum 2 cycles per turn. Ready is 0 during CHK.
- clear_boards is high the cycle after start is sampled. T_JUG starts on that same cycle.
- Asynchronous reset mid-shot (CHK) produces no wr_en.

## Configuration
- TURN_TIMEOUT_EN defined:
  - A cycle counter restarts on each entry to T_JUG.
  - After TIMEOUT_CYCLES cycles in T_JUG without acceptance: timeout pulses and state goes to T_PC, with no write.
  - If jug_valid arrives in the expiry cycle, acceptance wins.
  - A re-entry to T_JUG after shot_err restarts the count.
- TURN_TIMEOUT_EN undefined: no counter. T_JUG waits indefinitely; timeout is tied to 0.

## Test plan
- Reset then start: clear_boards = 1 for one cycle, turno = 0, jug_ready = 1, counters 0.
- Player shoots (2,3) with cell_rd = 01: at T+2, wr_en = 1, wr_board = 1, wr_row = 2, wr_col = 3, wr_data = 11, hits_jug = 1, turno = 1.
- PC shoots (0,0) with cell_rd = 10, then (5,1): shot_err pulses twice, no wr_en, turno stays 1, pc_ready returns.
- Player reaches 3 hits (SHIP_CELLS = 3): game_over = 1, ganador = 0. Further jug_valid/pc_valid are ignored. start restarts the game.
- With TURN_TIMEOUT_EN: jug_valid held low for 15 cycles → timeout pulse, turno = 1, no wr_en. jug_valid on cycle 15 → shot accepted instead.
- rst asserted during CHK_JUG: all outputs 0 immediately, no wr_en; after release, state is IDLE.

Source files
------------

// File: rtl/control_turnos.sv
// -----------------------------------------------------------------------------
// control_turnos
//
// Turn sequencer and shot arbiter for the two 5x5 battleship boards.
// Cells are 2 bits: 00 water, 01 ship, 10 missed shot, 11 hit shot.
// The player path and the PC shot generator take turns. An accepted shot
// latches its target onto the read port, the returned cell is evaluated one
// cycle later, and the result is committed as a one-cycle write strobe on
// the opposing board. The block keeps per-side hit counts, pulses a board
// clear at game start and flags the winner.
//
// Optional feature macro: TURN_TIMEOUT_EN
//   defined   -> a player turn expires after TIMEOUT_CYCLES cycles without a
//                shot; timeout_o pulses and the turn passes to the PC.
//   undefined -> the player turn waits indefinitely; timeout_o stays 0.
//
// Ports
//   clk_i, rst_ni              clock (rising edge), async active-low reset
//   start_i                    one-cycle new-game pulse (IDLE/FIN only)
//   jug_valid_i/jug_ready_o    player shot handshake, target jug_row_i/jug_col_i
//   pc_valid_i/pc_ready_o      PC shot handshake, target pc_row_i/pc_col_i
//   rd_board_o/rd_row_o/rd_col_o  read address (board 0 player, 1 PC)
//   cell_rd_i                  combinational cell content at the read address
//   wr_en_o, wr_board_o, wr_row_o, wr_col_o, wr_data_o  write command
//   clear_boards_o             one-cycle pulse at game start
//   turno_o                    0 player turn, 1 PC turn
//   hits_jug_o, hits_pc_o      saturating hit counters
//   shot_err_o                 one-cycle pulse: shot rejected
//   timeout_o                  one-cycle pulse: player turn expired
//   game_over_o, ganador_o     end flag and winner (0 player, 1 PC)
// -----------------------------------------------------------------------------
module control_turnos #(
  parameter int N              = 5,
  parameter int SHIP_CELLS     = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic                              jug_valid_i,
  output logic                              jug_ready_o,
  input  logic [2:0]                        jug_row_i,
  input  logic [2:0]                        jug_col_i,
  input  logic                              pc_valid_i,
  output logic                              pc_ready_o,
  input  logic [2:0]                        pc_row_i,
  input  logic [2:0]                        pc_col_i,
  output logic                              rd_board_o,
  output logic [2:0]                        rd_row_o,
  output logic [2:0]                        rd_col_o,
  input  logic [1:0]                        cell_rd_i,
  output logic                              wr_en_o,
  output logic                              wr_board_o,
  output logic [2:0]                        wr_row_o,
  output logic [2:0]                        wr_col_o,
  output logic [1:0]                        wr_data_o,
  output logic                              clear_boards_o,
  output logic                              turno_o,
  output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_jug_o,
  output logic [$clog2(SHIP_CELLS+1)-1:0]   hits_pc_o,
  output logic                              shot_err_o,
  output logic                              timeout_o,
  output logic                              game_over_o,
  output logic                              ganador_o
);

  localparam int CW = $clog2(SHIP_CELLS + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    T_JUG   = 3'd1,
    CHK_JUG = 3'd2,
    T_PC    = 3'd3,
    CHK_PC  = 3'd4,
    FIN     = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic            rd_board_q, rd_board_d;
  logic [2:0]      rd_row_q, rd_row_d;
  logic [2:0]      rd_col_q, rd_col_d;
  logic            wr_en_q, wr_en_d;
  logic            wr_board_q, wr_board_d;
  logic [2:0]      wr_row_q, wr_row_d;
  logic [2:0]      wr_col_q, wr_col_d;
  logic [1:0]      wr_data_q, wr_data_d;
  logic            clear_q, clear_d;
  logic [CW-1:0]   hits_jug_q, hits_jug_d;
  logic [CW-1:0]   hits_pc_q, hits_pc_d;
  logic            shot_err_q, shot_err_d;
  logic            timeout_q, timeout_d;
  logic            game_over_q, game_over_d;
  logic            ganador_q, ganador_d;

  logic            tmo_expired;
  logic            is_pc;
  logic            out_of_range;
  logic [CW-1:0]   shooter_hits;
  logic [CW-1:0]   hits_inc;

  // ---------------------------------------------------------------------------
  // Player turn timer
  // ---------------------------------------------------------------------------
`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Any state other than T_JUG zeroes the count, so every entry into T_JUG
  // (from start, from a finished PC turn or after a rejected shot) restarts it.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == T_JUG) begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // High during the last allowed cycle of the player turn.
  assign tmo_expired = (state_q == T_JUG) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Shot evaluation helpers (meaningful in CHK_JUG / CHK_PC)
  // ---------------------------------------------------------------------------
  assign is_pc        = (state_q == CHK_PC);
  assign out_of_range = (rd_row_q >= 3'(N)) || (rd_col_q >= 3'(N));
  assign shooter_hits = is_pc ? hits_pc_q : hits_jug_q;
  assign hits_inc     = (shooter_hits < CW'(SHIP_CELLS)) ? shooter_hits + CW'(1)
                                                        : shooter_hits;

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rd_board_d  = rd_board_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    wr_en_d     = 1'b0;
    wr_board_d  = wr_board_q;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_data_d   = wr_data_q;
    clear_d     = 1'b0;
    hits_jug_d  = hits_jug_q;
    hits_pc_d   = hits_pc_q;
    shot_err_d  = 1'b0;
    timeout_d   = 1'b0;
    game_over_d = game_over_q;
    ganador_d   = ganador_q;

    case (state_q)
      IDLE, FIN: begin
        if (start_i) begin
          clear_d     = 1'b1;
          hits_jug_d  = '0;
          hits_pc_d   = '0;
          game_over_d = 1'b0;
          ganador_d   = 1'b0;
          state_d     = T_JUG;
        end
      end

      T_JUG: begin
        // Acceptance takes priority over an expiry in the same cycle.
        if (jug_valid_i) begin
          rd_board_d = 1'b1;
          rd_row_d   = jug_row_i;
          rd_col_d   = jug_col_i;
          state_d    = CHK_JUG;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = T_PC;
        end
      end

      T_PC: begin
        if (pc_valid_i) begin
          rd_board_d = 1'b0;
          rd_row_d   = pc_row_i;
          rd_col_d   = pc_col_i;
          state_d    = CHK_PC;
        end
      end

      CHK_JUG, CHK_PC: begin
        if (out_of_range || cell_rd_i[1]) begin
          // Invalid or repeated target: the same side shoots again.
          shot_err_d = 1'b1;
          state_d    = is_pc ? T_PC : T_JUG;
        end else begin
          wr_en_d    = 1'b1;
          wr_board_d = rd_board_q;
          wr_row_d   = rd_row_q;
          wr_col_d   = rd_col_q;
          // Water becomes a miss (10), ship becomes a hit (11).
          wr_data_d  = {1'b1, cell_rd_i[0]};
          state_d    = is_pc ? T_JUG : T_PC;
          if (cell_rd_i[0]) begin
            if (is_pc) begin
              hits_pc_d = hits_inc;
            end else begin
              hits_jug_d = hits_inc;
            end
            if (hits_inc == CW'(SHIP_CELLS)) begin
              game_over_d = 1'b1;
              ganador_d   = is_pc;
              state_d     = FIN;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rd_board_q  <= 1'b0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_board_q  <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_data_q   <= '0;
      clear_q     <= 1'b0;
      hits_jug_q  <= '0;
      hits_pc_q   <= '0;
      shot_err_q  <= 1'b0;
      timeout_q   <= 1'b0;
      game_over_q <= 1'b0;
      ganador_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_board_q  <= rd_board_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      wr_en_q     <= wr_en_d;
      wr_board_q  <= wr_board_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_data_q   <= wr_data_d;
      clear_q     <= clear_d;
      hits_jug_q  <= hits_jug_d;
      hits_pc_q   <= hits_pc_d;
      shot_err_q  <= shot_err_d;
      timeout_q   <= timeout_d;
      game_over_q <= game_over_d;
      ganador_q   <= ganador_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign jug_ready_o    = (state_q == T_JUG);
  assign pc_ready_o     = (state_q == T_PC);
  assign turno_o        = (state_q == T_PC) || (state_q == CHK_PC);
  assign rd_board_o     = rd_board_q;
  assign rd_row_o       = rd_row_q;
  assign rd_col_o       = rd_col_q;
  assign wr_en_o        = wr_en_q;
  assign wr_board_o     = wr_board_q;
  assign wr_row_o       = wr_row_q;
  assign wr_col_o       = wr_col_q;
  assign wr_data_o      = wr_data_q;
  assign clear_boards_o = clear_q;
  assign hits_jug_o     = hits_jug_q;
  assign hits_pc_o      = hits_pc_q;
  assign shot_err_o     = shot_err_q;
  assign timeout_o      = timeout_q;
  assign game_over_o    = game_over_q;
  assign ganador_o      = ganador_q;

endmodule

// File: tb/tb_control_turnos.sv
// -----------------------------------------------------------------------------
// tb_control_turnos
//
// Self-checking bench for control_turnos. A small board store answers the
// read port combinationally, applies write strobes and loads a fixed ship
// layout on clear_boards. Shots come from a table of {target, expected
// result} records; each expected record is queued when the shot is driven
// and popped when the DUT reports the result two cycles later.
// Build with +define+TURN_TIMEOUT_EN to exercise the player-turn timeout.
// -----------------------------------------------------------------------------
module tb_control_turnos;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       jug_valid, pc_valid;
  logic       jug_ready, pc_ready;
  logic [2:0] jug_row, jug_col, pc_row, pc_col;
  logic       rd_board;
  logic [2:0] rd_row, rd_col;
  logic [1:0] cell_rd;
  logic       wr_en, wr_board;
  logic [2:0] wr_row, wr_col;
  logic [1:0] wr_data;
  logic       clear_boards, turno;
  logic [1:0] hits_jug, hits_pc;
  logic       shot_err, timeout, game_over, ganador;

  always #5 clk = ~clk;

  control_turnos dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .jug_valid_i    (jug_valid),
    .jug_ready_o    (jug_ready),
    .jug_row_i      (jug_row),
    .jug_col_i      (jug_col),
    .pc_valid_i     (pc_valid),
    .pc_ready_o     (pc_ready),
    .pc_row_i       (pc_row),
    .pc_col_i       (pc_col),
    .rd_board_o     (rd_board),
    .rd_row_o       (rd_row),
    .rd_col_o       (rd_col),
    .cell_rd_i      (cell_rd),
    .wr_en_o        (wr_en),
    .wr_board_o     (wr_board),
    .wr_row_o       (wr_row),
    .wr_col_o       (wr_col),
    .wr_data_o      (wr_data),
    .clear_boards_o (clear_boards),
    .turno_o        (turno),
    .hits_jug_o     (hits_jug),
    .hits_pc_o      (hits_pc),
    .shot_err_o     (shot_err),
    .timeout_o      (timeout),
    .game_over_o    (game_over),
    .ganador_o      (ganador)
  );

  // Board store: [board][row][col]; board 0 = player, 1 = PC.
  logic [1:0] board [2][5][5];

  assign cell_rd = (rd_row < 3'd5 && rd_col < 3'd5) ? board[rd_board][rd_row][rd_col] : 2'b00;

  always @(posedge clk) begin
    if (clear_boards) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            board[b][r][c] <= 2'b00;
      board[1][2][3] <= 2'b01;
      board[1][2][4] <= 2'b01;
      board[1][1][1] <= 2'b01;
      board[0][0][1] <= 2'b01;
      board[0][4][4] <= 2'b01;
      board[0][3][3] <= 2'b01;
    end else if (wr_en && wr_row < 3'd5 && wr_col < 3'd5) begin
      board[wr_board][wr_row][wr_col] <= wr_data;
    end
  end

  typedef struct {
    logic       side;   // 0 player, 1 PC
    logic [2:0] row;
    logic [2:0] col;
    logic       err;
    logic [1:0] wdata;
    logic [1:0] hj;
    logic [1:0] hp;
    logic       turno;
    logic       go;
    logic       gan;
  } vec_t;

  vec_t vecs [11];
  vec_t exp_q [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called with the shot's valid already asserted, one step before the
  // accepting edge. Checks the CHK cycle, then pops and checks the result.
  task automatic finish_shot(input logic side, input logic [2:0] row, input logic [2:0] col);
    vec_t e;
    @(posedge clk); #1;
    jug_valid = 1'b0;
    pc_valid  = 1'b0;
    check("chk_rd_board", rd_board, !side);
    check("chk_rd_row", rd_row, row);
    check("chk_rd_col", rd_col, col);
    check("chk_turno", turno, side);
    check("chk_ready_low", {jug_ready, pc_ready}, 2'b00);
    check("chk_timeout_low", timeout, 0);
    @(posedge clk); #1;
    check("result_present", wr_en | shot_err, 1);
    e = exp_q.pop_front();
    check("shot_err", shot_err, e.err);
    check("wr_en", wr_en, !e.err);
    if (!e.err) begin
      check("wr_data", wr_data, e.wdata);
      check("wr_board", wr_board, !e.side);
      check("wr_row", wr_row, e.row);
      check("wr_col", wr_col, e.col);
    end
    check("hits_jug", hits_jug, e.hj);
    check("hits_pc", hits_pc, e.hp);
    check("turno_after", turno, e.turno);
    check("game_over", game_over, e.go);
    check("ganador", ganador, e.gan);
    $display("shot side=%0d (%0d,%0d): err=%0d wr_en=%0d data=%b hits=%0d/%0d turno=%0d go=%0d gan=%0d",
             side, row, col, shot_err, wr_en, wr_data, hits_jug, hits_pc, turno, game_over, ganador);
  endtask

  task automatic do_shot(input vec_t v);
    int n = 0;
    while (((v.side ? pc_ready : jug_ready) !== 1'b1) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", v.side ? pc_ready : jug_ready, 1);
    exp_q.push_back(v);
    if (v.side) begin
      pc_valid = 1'b1; pc_row = v.row; pc_col = v.col;
    end else begin
      jug_valid = 1'b1; jug_row = v.row; jug_col = v.col;
    end
    finish_shot(v.side, v.row, v.col);
  endtask

  task automatic start_game();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("clear_pulse", clear_boards, 1);
    check("start_jug_ready", jug_ready, 1);
    check("start_pc_ready", pc_ready, 0);
    check("start_turno", turno, 0);
    check("start_hits", {hits_jug, hits_pc}, 4'h0);
    check("start_game_over", {game_over, ganador}, 2'b00);
    @(posedge clk); #1;
    check("clear_one_cycle", clear_boards, 0);
    $display("start: clear_boards pulsed, jug_ready=%0d turno=%0d", jug_ready, turno);
  endtask

  function automatic vec_t mk(input logic side, input logic [2:0] row, input logic [2:0] col,
                              input logic err, input logic [1:0] wdata, input logic [1:0] hj,
                              input logic [1:0] hp, input logic t, input logic go, input logic gan);
    vec_t v;
    v.side = side; v.row = row; v.col = col; v.err = err; v.wdata = wdata;
    v.hj = hj; v.hp = hp; v.turno = t; v.go = go; v.gan = gan;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic activity, any_ready, go_all, tmo_seen, rdy_all;

    //            side  row   col   err  wdata  hj    hp    turno go   gan
    vecs[0]  = mk(1'b0, 3'd2, 3'd3, 1'b0, 2'b11, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 3'd0, 3'd0, 1'b0, 2'b10, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 3'd0, 3'd0, 1'b0, 2'b10, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 3'd0, 3'd0, 1'b1, 2'b00, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 3'd5, 3'd1, 1'b1, 2'b00, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 3'd0, 3'd1, 1'b0, 2'b11, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 3'd2, 3'd3, 1'b1, 2'b00, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 3'd2, 3'd4, 1'b0, 2'b11, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 3'd4, 3'd4, 1'b0, 2'b11, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 3'd1, 3'd7, 1'b1, 2'b00, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 3'd1, 3'd1, 1'b0, 2'b11, 2'd3, 2'd2, 1'b0, 1'b1, 1'b0);

    rst_n = 1'b0; start = 1'b0;
    jug_valid = 1'b0; pc_valid = 1'b0;
    jug_row = '0; jug_col = '0; pc_row = '0; pc_col = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {wr_en, clear_boards, turno, shot_err, timeout, game_over, ganador}, 0);
    check("rst_counters", {hits_jug, hits_pc}, 0);
    check("rst_ready", {jug_ready, pc_ready}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", {jug_ready, pc_ready}, 0);
    $display("reset released: state idle, ready=%0d%0d", jug_ready, pc_ready);

    start_game();

    for (int i = 0; i < 11; i++) do_shot(vecs[i]);

    // Game over: further shots and the ready outputs stay quiet.
    jug_valid = 1'b1; jug_row = 3'd0; jug_col = 3'd2;
    pc_valid  = 1'b1; pc_row  = 3'd2; pc_col  = 3'd2;
    activity = 1'b0; any_ready = 1'b0; go_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      activity  = activity | wr_en | shot_err;
      any_ready = any_ready | jug_ready | pc_ready;
      go_all    = go_all & game_over;
    end
    jug_valid = 1'b0; pc_valid = 1'b0;
    check("fin_no_activity", activity, 0);
    check("fin_no_ready", any_ready, 0);
    check("fin_game_over_held", go_all, 1);
    $display("fin: activity=%0d ready=%0d game_over=%0d", activity, any_ready, go_all);

    start_game();

`ifdef TURN_TIMEOUT_EN
    // Two T_JUG cycles already elapsed; expiry lands on the 15th edge.
    tmo_seen = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      tmo_seen = tmo_seen | timeout;
    end
    check("tmo_early", tmo_seen, 0);
    @(posedge clk); #1;
    check("tmo_pulse", timeout, 1);
    check("tmo_turno", turno, 1);
    check("tmo_no_wr", wr_en, 0);
    check("tmo_pc_ready", pc_ready, 1);
    @(posedge clk); #1;
    check("tmo_one_cycle", timeout, 0);
    $display("timeout: turn passed to PC, turno=%0d", turno);

    do_shot(mk(1'b1, 3'd1, 3'd0, 1'b0, 2'b10, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    // Back in T_JUG from the edge just passed; shoot in the expiry cycle.
    for (int i = 0; i < 14; i++) @(posedge clk);
    #1;
    check("tmo_late_ready", jug_ready, 1);
    exp_q.push_back(mk(1'b0, 3'd0, 3'd2, 1'b0, 2'b10, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0));
    jug_valid = 1'b1; jug_row = 3'd0; jug_col = 3'd2;
    finish_shot(1'b0, 3'd0, 3'd2);
`else
    tmo_seen = 1'b0; rdy_all = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tmo_seen = tmo_seen | timeout;
      rdy_all  = rdy_all & jug_ready;
    end
    check("no_timeout", tmo_seen, 0);
    check("jug_waits", rdy_all, 1);
    $display("no timeout: jug_ready held for 20 cycles");
    do_shot(mk(1'b0, 3'd0, 3'd2, 1'b0, 2'b10, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0));
`endif

    // Reset while a player shot is in CHK_JUG.
    do_shot(mk(1'b1, 3'd2, 3'd2, 1'b0, 2'b10, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
    jug_valid = 1'b1; jug_row = 3'd3; jug_col = 3'd2;
    @(posedge clk); #1;
    jug_valid = 1'b0;
    check("pre_rst_chk", rd_row, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd", {rd_board, rd_row, rd_col}, 0);
    check("mid_rst_wr", {wr_en, wr_board, wr_row, wr_col, wr_data}, 0);
    check("mid_rst_flags", {clear_boards, turno, shot_err, timeout, game_over, ganador}, 0);
    check("mid_rst_ready", {jug_ready, pc_ready}, 0);
    @(posedge clk); #1;
    check("mid_rst_no_wr", wr_en, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {jug_ready, pc_ready, wr_en, shot_err}, 0);
    $display("reset in CHK_JUG: wr_en=%0d ready=%0d%0d", wr_en, jug_ready, pc_ready);

    start_game();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
